// File: rtl/lfsr_prbs_checker_if.sv
// Serial PRBS link bundle between a bit-stream source (master) and lfsr_prbs_checker (slave).
// The bit_count signal exists only when LFSR_CHK_BITCNT_EN is defined.
interface lfsr_prbs_checker_if;
    logic        bit_in;
    logic        bit_valid;
    logic        clear_cnt;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
`ifdef LFSR_CHK_BITCNT_EN
    logic [31:0] bit_count;

    modport master (
        output bit_in, bit_valid, clear_cnt,
        input  locked, err_pulse, err_count, bit_count
    );
    modport slave (
        input  bit_in, bit_valid, clear_cnt,
        output locked, err_pulse, err_count, bit_count
    );
`else
    modport master (
        output bit_in, bit_valid, clear_cnt,
        input  locked, err_pulse, err_count
    );
    modport slave (
        input  bit_in, bit_valid, clear_cnt,
        output locked, err_pulse, err_count
    );
`endif
endinterface

// File: rtl/lfsr_prbs_checker.sv
// Self-synchronising checker for the 8-bit Galois LFSR PRBS stream; flags and counts bit errors.
// Optional 32-bit locked-sample counter enabled by defining LFSR_CHK_BITCNT_EN.
module lfsr_prbs_checker #(
    parameter logic [7:0]  TAPS       = 8'hB8,
    parameter int unsigned LOCK_COUNT = 16,
    parameter int unsigned LOSS_COUNT = 4
) (
    input  logic                clk,
    input  logic                reset,
    lfsr_prbs_checker_if.slave  bus
);
    localparam logic [7:0] LOCK_CNT = LOCK_COUNT[7:0];
    localparam logic [3:0] LOSS_CNT = LOSS_COUNT[3:0];

    typedef enum logic {SEARCH, LOCKED} state_t;

    state_t      state_q, state_d;
    logic [7:0]  hist_q, hist_d;
    logic [3:0]  fill_q, fill_d;
    logic [7:0]  good_q, good_d;
    logic [3:0]  bad_q, bad_d;
    logic        locked_q, locked_d;
    logic        err_pulse_q, err_pulse_d;
    logic [15:0] err_count_q, err_count_d;
    logic        pred;
    logic        mismatch;
    logic        count_err;

    assign pred     = ^(hist_q & TAPS);
    assign mismatch = bus.bit_in ^ pred;

    // In LOCKED the history is fed from its own prediction, so a line error cannot corrupt it.
    always_comb begin
        state_d     = state_q;
        hist_d      = hist_q;
        fill_d      = fill_q;
        good_d      = good_q;
        bad_d       = bad_q;
        locked_d    = locked_q;
        err_pulse_d = 1'b0;
        count_err   = 1'b0;
        if (bus.bit_valid) begin
            case (state_q)
                SEARCH: begin
                    hist_d = {hist_q[6:0], bus.bit_in};
                    if (fill_q < 4'd8) begin
                        fill_d = fill_q + 4'd1;
                    end else begin
                        good_d = mismatch ? 8'd0 : good_q + 8'd1;
                        if (hist_d == 8'd0) begin
                            good_d = 8'd0;
                        end
                        if (good_d == LOCK_CNT) begin
                            state_d  = LOCKED;
                            bad_d    = 4'd0;
                            locked_d = 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    hist_d = {hist_q[6:0], pred};
                    if (mismatch) begin
                        err_pulse_d = 1'b1;
                        count_err   = 1'b1;
                        bad_d       = bad_q + 4'd1;
                        if (bad_d == LOSS_CNT) begin
                            state_d  = SEARCH;
                            fill_d   = 4'd0;
                            good_d   = 8'd0;
                            locked_d = 1'b0;
                        end
                    end else begin
                        bad_d = 4'd0;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    // A clear coinciding with a counted error leaves that error in the count.
    always_comb begin
        err_count_d = bus.clear_cnt ? 16'd0 : err_count_q;
        if (count_err && (err_count_d != 16'hFFFF)) begin
            err_count_d = err_count_d + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SEARCH;
            hist_q      <= 8'd0;
            fill_q      <= 4'd0;
            good_q      <= 8'd0;
            bad_q       <= 4'd0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            hist_q      <= hist_d;
            fill_q      <= fill_d;
            good_q      <= good_d;
            bad_q       <= bad_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
        end
    end

    assign bus.locked    = locked_q;
    assign bus.err_pulse = err_pulse_q;
    assign bus.err_count = err_count_q;

`ifdef LFSR_CHK_BITCNT_EN
    logic [31:0] bit_count_q, bit_count_d;
    logic        count_bit;

    assign count_bit = bus.bit_valid && (state_q == LOCKED);

    always_comb begin
        bit_count_d = bus.clear_cnt ? 32'd0 : bit_count_q;
        if (count_bit) begin
            bit_count_d = bit_count_d + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_count_q <= 32'd0;
        end else begin
            bit_count_q <= bit_count_d;
        end
    end

    assign bus.bit_count = bit_count_q;
`endif
endmodule

// File: tb/tb_lfsr_prbs_checker.sv
// Directed testbench for lfsr_prbs_checker driven by a Galois 8-bit reference generator (0x1D, seed 0xFF).
// Table rows cover steady-state error patterns; hand sequences cover lock/drop timing, reset and clear.
module tb_lfsr_prbs_checker;
    logic clk = 1'b0;
    logic reset;
    logic [7:0] gen;
    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int lockSeen = 0;

    lfsr_prbs_checker_if bus();

    lfsr_prbs_checker #(
        .TAPS       (8'hB8),
        .LOCK_COUNT (16),
        .LOSS_COUNT (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    nSamples;
        int    nInvert;
        logic  expLocked;
        int    expErr;
        int    expPulses;
    } vector_t;

    vector_t vectors[4];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic b, input logic v, input logic clr);
        bus.bit_in    = b;
        bus.bit_valid = v;
        bus.clear_cnt = clr;
        @(posedge clk);
        #1;
        bus.bit_valid = 1'b0;
        bus.clear_cnt = 1'b0;
        if (bus.err_pulse === 1'b1) pulses++;
        if (bus.locked === 1'b1) lockSeen++;
    endtask

    task automatic sendGen(input logic inv, input logic clr);
        logic b;
        b   = gen[7];
        gen = {gen[6:0], 1'b0} ^ (b ? 8'h1D : 8'h00);
        applyStimulus(b ^ inv, 1'b1, clr);
    endtask

    task automatic doReset();
        reset = 1'b1;
        gen   = 8'hFF;
        applyStimulus(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        int gaps;
        bus.bit_in    = 1'b0;
        bus.bit_valid = 1'b0;
        bus.clear_cnt = 1'b0;
        reset         = 1'b1;
        gen           = 8'hFF;

        vectors[0] = '{"clean",     8, 0, 1'b1, 0, 0};
        vectors[1] = '{"one_err",   6, 1, 1'b1, 1, 1};
        vectors[2] = '{"three_err", 5, 3, 1'b1, 4, 3};
        vectors[3] = '{"clean2",    4, 0, 1'b1, 4, 0};

        doReset();
        checkOutput("reset_locked", 32'(bus.locked), 0);
        checkOutput("reset_err_pulse", 32'(bus.err_pulse), 0);
        checkOutput("reset_err_count", 32'(bus.err_count), 0);
`ifdef LFSR_CHK_BITCNT_EN
        checkOutput("reset_bit_count", bus.bit_count, 0);
`endif

        // Continuous stream: lock exactly after the 24th valid sample
        for (int i = 0; i < 23; i++) sendGen(1'b0, 1'b0);
        checkOutput("lock_not_at_23", 32'(bus.locked), 0);
        sendGen(1'b0, 1'b0);
        checkOutput("lock_at_24", 32'(bus.locked), 1);
        checkOutput("lock_err_count", 32'(bus.err_count), 0);
`ifdef LFSR_CHK_BITCNT_EN
        checkOutput("lock_bit_count", bus.bit_count, 0);
`endif

        for (int v = 0; v < 4; v++) begin
            pulses = 0;
            for (int s = 0; s < vectors[v].nSamples; s++) sendGen(s < vectors[v].nInvert, 1'b0);
            checkOutput({vectors[v].name, "_locked"}, 32'(bus.locked), 32'(vectors[v].expLocked));
            checkOutput({vectors[v].name, "_err_count"}, 32'(bus.err_count), vectors[v].expErr);
            checkOutput({vectors[v].name, "_pulses"}, pulses, vectors[v].expPulses);
        end
`ifdef LFSR_CHK_BITCNT_EN
        checkOutput("table_bit_count", bus.bit_count, 23);
`endif

        // Four consecutive errors drop lock on the fourth, then relock 24 samples later
        for (int i = 0; i < 3; i++) sendGen(1'b1, 1'b0);
        checkOutput("drop_locked_after_3", 32'(bus.locked), 1);
        sendGen(1'b1, 1'b0);
        checkOutput("drop_locked_after_4", 32'(bus.locked), 0);
        checkOutput("drop_err_pulse", 32'(bus.err_pulse), 1);
        checkOutput("drop_err_count", 32'(bus.err_count), 8);
`ifdef LFSR_CHK_BITCNT_EN
        checkOutput("drop_bit_count", bus.bit_count, 27);
`endif
        pulses = 0;
        for (int i = 0; i < 23; i++) sendGen(1'b0, 1'b0);
        checkOutput("relock_not_at_23", 32'(bus.locked), 0);
        sendGen(1'b0, 1'b0);
        checkOutput("relock_at_24", 32'(bus.locked), 1);
        checkOutput("relock_err_count", 32'(bus.err_count), 8);
        checkOutput("relock_pulses", pulses, 0);
`ifdef LFSR_CHK_BITCNT_EN
        checkOutput("relock_bit_count", bus.bit_count, 27);
`endif

        // Reset while locked, coincident with an erroneous valid sample
        reset = 1'b1;
        applyStimulus(~gen[7], 1'b1, 1'b0);
        reset = 1'b0;
        checkOutput("midreset_locked", 32'(bus.locked), 0);
        checkOutput("midreset_err_count", 32'(bus.err_count), 0);
        checkOutput("midreset_err_pulse", 32'(bus.err_pulse), 0);
`ifdef LFSR_CHK_BITCNT_EN
        checkOutput("midreset_bit_count", bus.bit_count, 0);
`endif

        // clear_cnt coincident with a counted error keeps that error
        gen = 8'hFF;
        for (int i = 0; i < 24; i++) sendGen(1'b0, 1'b0);
        checkOutput("clr_locked", 32'(bus.locked), 1);
        sendGen(1'b1, 1'b0);
        sendGen(1'b0, 1'b0);
        sendGen(1'b1, 1'b0);
        checkOutput("clr_err_before", 32'(bus.err_count), 2);
        sendGen(1'b1, 1'b1);
        checkOutput("clr_with_error", 32'(bus.err_count), 1);
        checkOutput("clr_with_error_pulse", 32'(bus.err_pulse), 1);
`ifdef LFSR_CHK_BITCNT_EN
        checkOutput("clr_with_error_bits", bus.bit_count, 1);
`endif
        sendGen(1'b0, 1'b1);
        checkOutput("clr_plain", 32'(bus.err_count), 0);
        checkOutput("clr_keeps_lock", 32'(bus.locked), 1);

        // All-zero stream must never lock
        doReset();
        pulses   = 0;
        lockSeen = 0;
        for (int i = 0; i < 1000; i++) applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("zeros_lock_seen", lockSeen, 0);
        checkOutput("zeros_err_count", 32'(bus.err_count), 0);
        checkOutput("zeros_pulses", pulses, 0);

        // Random valid gaps with junk bit_in in idle cycles: same lock point in valid samples
        doReset();
        pulses = 0;
        for (int i = 0; i < 24; i++) begin
            gaps = int'($urandom_range(0, 2));
            for (int g = 0; g < gaps; g++) applyStimulus(1'($urandom_range(0, 1)), 1'b0, 1'b0);
            if (i == 23) checkOutput("gaps_not_at_23", 32'(bus.locked), 0);
            sendGen(1'b0, 1'b0);
        end
        checkOutput("gaps_lock_at_24", 32'(bus.locked), 1);
        for (int i = 0; i < 10; i++) begin
            gaps = int'($urandom_range(0, 2));
            for (int g = 0; g < gaps; g++) applyStimulus(1'($urandom_range(0, 1)), 1'b0, 1'b0);
            sendGen(1'b0, 1'b0);
        end
        checkOutput("gaps_err_count", 32'(bus.err_count), 0);
        checkOutput("gaps_pulses", pulses, 0);
        checkOutput("gaps_locked", 32'(bus.locked), 1);
`ifdef LFSR_CHK_BITCNT_EN
        checkOutput("gaps_bit_count", bus.bit_count, 10);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
